// File: rtl/uart_pkg.sv
// Shared constants and drain-state encoding for the UART transmit FIFO.
package uart_pkg;

    localparam int DEPTH_DEF    = 16;
    localparam int BUSY_TMO_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } drain_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte FIFO storage with wrapping pointers; full/empty come from the occupancy count.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [7:0]               din_i,
    input  logic                     pop_i,
    output logic [7:0]               head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    // Callers guarantee push_i only when not full and pop_i only when not empty.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) wptr_d = wptr_q + 1'b1;
        if (pop_i)  rptr_d = rptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-side transmit FIFO that drains bytes into a UART serializer one launch at a time.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int BUSY_TMO = BUSY_TMO_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_i,
    input  logic [7:0]               dat_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o,
    input  logic                     ovf_clr_i,
    input  logic                     uart_busy,
    output logic                     uart_wr_o,
    output logic [7:0]               uart_dat_o,
    output drain_state_e             state_o
);

    localparam int TMO_W = $clog2(BUSY_TMO + 1);

    drain_state_e state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0] dat_q, dat_d;
    logic ovf_q, ovf_d;
    logic push, pop;
    logic [7:0] head;
    logic full, empty;

    // Fullness is judged before any same-cycle pop, so a push at full is always dropped.
    assign push = wr_i && !full;

    uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (dat_i),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i)          ovf_d = 1'b0;
        else if (wr_i && full)  ovf_d = 1'b1;
    end

    // Launch handshake: uart_wr_o is a single-cycle strobe with uart_dat_o valid in
    // the same cycle; the serializer acknowledges by raising uart_busy and signals
    // completion by dropping it. No busy within BUSY_TMO cycles counts as sent.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        dat_d   = dat_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty && !uart_busy) begin
                    state_d = ST_LAUNCH;
                    dat_d   = head;
                end
            end
            ST_LAUNCH: begin
                pop     = 1'b1;
                tmo_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (uart_busy)                             state_d = ST_WAIT_DONE;
                else if (tmo_q == TMO_W'(BUSY_TMO - 1))    state_d = ST_IDLE;
                else                                       tmo_d   = tmo_q + 1'b1;
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            dat_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            dat_q   <= dat_d;
            ovf_q   <= ovf_d;
        end
    end

    assign full_o     = full;
    assign empty_o    = empty;
    assign ovf_o      = ovf_q;
    assign uart_wr_o  = (state_q == ST_LAUNCH);
    assign uart_dat_o = dat_q;
    assign state_o    = state_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter BUSY_TMO, default 4, meaning max cycles waited for uart_busy to rise after a launch.
REQ-003 SHALL have port clk  in  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_i  in  1  push strobe from CPU peripheral, one byte per cycle high.
REQ-006 SHALL have port dat_i  in  8  byte to push.
REQ-007 SHALL have port full_o  out  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port empty_o  out  1  FIFO holds zero entries.
REQ-009 SHALL have port count_o  out  log2(DEPTH)+1  current occupancy.
REQ-010 SHALL have port ovf_o  out  1  sticky overflow flag.
REQ-011 SHALL have port ovf_clr_i  in  1  clears ovf_o.
REQ-012 SHALL have port uart_busy  in  1  busy from downstream serializer.
REQ-013 SHALL have port uart_wr_o  out  1  one-cycle launch strobe to serializer.
REQ-014 SHALL have port uart_dat_o  out  8  byte presented with uart_wr_o.

Function
REQ-015 SHALL push dat_i when wr_i=1 and full_o=0; count increments next edge.
REQ-016 SHALL drop the push and set ovf_o when wr_i=1 and full_o=1, even if a pop occurs that cycle (full evaluated before pop).
REQ-017 SHALL give ovf_clr_i priority over a simultaneous overflow set (clear wins).
REQ-018 SHALL run drain FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-019 SHALL go IDLE->LAUNCH when empty_o=0 and uart_busy=0; else stay IDLE.
REQ-020 SHALL assert uart_wr_o for exactly the one cycle spent in LAUNCH, with uart_dat_o equal to FIFO head, then pop and go WAIT_BUSY.
REQ-021 SHALL go WAIT_BUSY->WAIT_DONE when uart_busy=1; after BUSY_TMO cycles without busy SHALL return to IDLE (byte considered sent).
REQ-022 SHALL go WAIT_DONE->IDLE when uart_busy=0.
REQ-023 SHALL give latency: push at edge N into empty FIFO in IDLE with busy=0 -> uart_wr_o high between edges N+1 and N+2.
REQ-024 SHALL handle simultaneous push and pop: count unchanged, both take effect.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; full/empty derived from count, never from pointer equality alone.
REQ-026 SHALL hold uart_dat_o stable at last launched byte outside LAUNCH.
REQ-027 SHALL never issue a second uart_wr_o before uart_busy has fallen or the timeout has expired.

Reset
REQ-028 SHALL, on rst=0, immediately force: state IDLE, pointers 0, count_o 0, empty_o 1, full_o 0, ovf_o 0, uart_wr_o 0, uart_dat_o 0.
REQ-029 SHALL discard FIFO contents and any in-flight launch on reset mid-operation; storage array need not be cleared.
REQ-030 SHALL release reset synchronously to clk from the integrator's reset synchronizer; no internal synchronizer.

Structure
REQ-031 SHALL place drain-state enumeration and default DEPTH/BUSY_TMO constants in shared package uart_pkg.
REQ-032 SHALL implement storage plus pointers/count as sub-module uart_fifo_mem; FSM and overflow logic stay in uart_tx_fifo.

Verification
REQ-033 SHALL check: push 0x41 with busy=0 -> uart_wr_o one cycle at edge+1, uart_dat_o=0x41, count 1->0.
REQ-034 SHALL check: push 0x01..0x10 (16) while busy=1 -> full_o=1, count_o=16; 17th push 0xFF -> dropped, ovf_o=1; ovf_clr_i -> ovf_o=0.
REQ-035 SHALL check: model busy high 10 cycles after each wr -> bytes 0x01..0x10 emitted in order, one strobe per busy low period.
REQ-036 SHALL check: busy never rises after launch -> FSM returns IDLE after 4 cycles, next byte launched.
REQ-037 SHALL check: push and launch-pop same cycle with count=3 -> count stays 3; push at full with pop -> dropped, ovf_o=1.
REQ-038 SHALL check: rst=0 during WAIT_DONE with 5 queued -> all outputs at reset values asynchronously, no uart_wr_o after release until new push.
